// File: rtl/mpu_pio_bridge_if.sv
// Bus bundle between the soft-CPU PIO pair / matrix core and the PIO command bridge.
// slave: the bridge; master: the host plus the operations core driving the bridge.
interface mpu_pio_bridge_if #(
  parameter int unsigned N_BITS = 200
);
  logic [31:0]       pio_out;
  logic [31:0]       pio_in;
  logic              op_start;
  logic [2:0]        op_code;
  logic [7:0]        op_size;
  logic [N_BITS-1:0] op_a;
  logic [N_BITS-1:0] op_b;
  logic              op_done;
  logic [N_BITS-1:0] op_result;
  logic              busy;

  modport slave (
    input  pio_out, op_done, op_result,
    output pio_in, op_start, op_code, op_size, op_a, op_b, busy
  );

  modport master (
    output pio_out, op_done, op_result,
    input  pio_in, op_start, op_code, op_size, op_a, op_b, busy
  );
endinterface

// File: rtl/mpu_pio_bridge.sv
// PIO command bridge: chunked operand load, launch with op_done timeout, bytewise readback,
// error reporting and host abort.
module mpu_pio_bridge #(
  parameter int unsigned N_BITS       = 200,
  parameter int unsigned CHUNK        = 8,
  parameter int unsigned EXEC_TIMEOUT = 1024
) (
  input logic             clock,
  input logic             reset_n,
  mpu_pio_bridge_if.slave bus
);
  localparam int unsigned N_CHUNKS = (N_BITS + CHUNK - 1) / CHUNK;
  localparam int unsigned N_BYTES  = (N_BITS + 7) / 8;
  localparam int unsigned RES_W    = N_BYTES * 8;
  localparam int unsigned IDX_W    = (RES_W > 8) ? $clog2(RES_W) : 3;
  localparam int unsigned CNT_W    = $clog2(N_CHUNKS + 1);
  localparam int unsigned TMR_W    = $clog2(EXEC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadA = 3'd1,
    StLoadB = 3'd2,
    StExec  = 3'd3,
    StRead  = 3'd4,
    StError = 3'd5
  } state_e;

  state_e            state;
  logic              strobe_prev, ack_prev, abort_prev;
  logic              strobe_edge, ack_edge, abort_edge;
  logic [CNT_W-1:0]  chunk_cnt;
  logic [TMR_W-1:0]  timer;
  logic [7:0]        byte_idx;
  logic [7:0]        data;
  logic              valid;
  logic              err;
  logic              start;
  logic [2:0]        code;
  logic [7:0]        size;
  logic [N_BITS-1:0] op_a_q, op_b_q;
  logic [RES_W-1:0]  result;
  logic [N_BITS-1:0] load_src, load_merged;
  logic [IDX_W-1:0]  bit_base;
  logic [7:0]        result_byte;

  assign strobe_edge = bus.pio_out[31] & ~strobe_prev;
  assign ack_edge    = bus.pio_out[26] & ~ack_prev;
  assign abort_edge  = bus.pio_out[25] & ~abort_prev;

  // Overlay the incoming chunk onto the target operand; bits past N_BITS simply have no home.
  assign load_src = (state == StLoadB) ? op_b_q : op_a_q;
  always_comb begin
    load_merged = load_src;
    for (int i = 0; i < N_BITS; i++) begin
      if (chunk_cnt == CNT_W'(i / CHUNK)) load_merged[i] = bus.pio_out[i % CHUNK];
    end
  end

  assign bit_base    = IDX_W'({byte_idx, 3'b000});
  assign result_byte = result[bit_base +: 8];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      strobe_prev <= 1'b0;
      ack_prev    <= 1'b0;
      abort_prev  <= 1'b0;
      chunk_cnt   <= '0;
      timer       <= '0;
      byte_idx    <= '0;
      data        <= '0;
      valid       <= 1'b0;
      err         <= 1'b0;
      start       <= 1'b0;
      code        <= '0;
      size        <= 8'd3;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result      <= '0;
    end else begin
      strobe_prev <= bus.pio_out[31];
      ack_prev    <= bus.pio_out[26];
      abort_prev  <= bus.pio_out[25];
      start       <= 1'b0;
      if (abort_edge) begin
        state     <= StIdle;
        chunk_cnt <= '0;
        timer     <= '0;
        byte_idx  <= '0;
        valid     <= 1'b0;
        err       <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (strobe_edge) begin
              code      <= bus.pio_out[29:27];
              size      <= bus.pio_out[30] ? 8'd2 : 8'd3;
              chunk_cnt <= '0;
              state     <= StLoadA;
            end
          end
          StLoadA, StLoadB: begin
            if (strobe_edge) begin
              if (state == StLoadA) op_a_q <= load_merged;
              else                  op_b_q <= load_merged;
              if (chunk_cnt == CNT_W'(N_CHUNKS - 1)) begin
                chunk_cnt <= '0;
                if (state == StLoadA) begin
                  state <= StLoadB;
                end else begin
                  state <= StExec;
                  start <= 1'b1;
                  timer <= '0;
                end
              end else begin
                chunk_cnt <= chunk_cnt + 1'b1;
              end
            end
          end
          StExec: begin
            if (bus.op_done) begin
              result   <= RES_W'(bus.op_result);
              byte_idx <= '0;
              timer    <= '0;
              state    <= StRead;
            end else if (timer == TMR_W'(EXEC_TIMEOUT - 1)) begin
              err   <= 1'b1;
              timer <= '0;
              state <= StError;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          StRead: begin
            if (!valid) begin
              data  <= result_byte;
              valid <= 1'b1;
            end else if (ack_edge) begin
              valid <= 1'b0;
              if (byte_idx == 8'(N_BYTES - 1)) state <= StIdle;
              else                             byte_idx <= byte_idx + 8'd1;
            end
          end
          StError: ;
          default: state <= StIdle;
        endcase
      end
    end
  end

  assign bus.pio_in   = {valid, err, state, byte_idx, 11'd0, data};
  assign bus.op_start = start;
  assign bus.op_code  = code;
  assign bus.op_size  = size;
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.busy     = (state != StIdle);
endmodule
